// File: rtl/lpf_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpf_channel_scheduler: round-robin sharing of one single-pole LPF datapath |
// | across NCH channels. Optional macro LPF_PRIME_EN seeds state from sample 1.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module lpf_channel_scheduler #(
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int DW    = 20,
  parameter int K_RST = 4
) (
  input  logic              qzt_clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    smp_stb,
  input  logic [NCH*DW-1:0] vin_flat,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [3:0]        cfg_k,
  input  logic              ovr_clr,
  output logic [DW-1:0]     vout,
  output logic [CHW-1:0]    vout_ch,
  output logic              vout_valid,
  output logic [NCH-1:0]    ovr,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           r_state;
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_ovr;
  logic [DW-1:0]    r_xin [NCH];
  logic [DW-1:0]    r_y   [NCH];
  logic [3:0]       r_k   [NCH];
  logic [CHW-1:0]   r_ptr;
  logic [CHW-1:0]   r_g;
  logic [DW-1:0]    r_x;
  logic [DW-1:0]    r_yp;
  logic [3:0]       r_kw;
  logic [DW-1:0]    r_res;

  logic             w_found;
  logic [CHW-1:0]   w_gnt;
  logic             w_load;
  logic [CHW-1:0]   w_next_ptr;
  logic signed [DW:0] w_diff;
  logic signed [DW:0] w_step;
  logic [DW-1:0]    w_filt;
  logic [DW-1:0]    w_calc;

  // Scan downward so the candidate closest to the pointer is the one kept.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      int j;
      logic [CHW-1:0] w_j;
      j = int'(r_ptr) + i;
      if (j >= NCH) j = j - NCH;
      w_j = CHW'(j);
      if (r_pend[w_j]) begin
        w_found = 1'b1;
        w_gnt   = w_j;
      end
    end
  end

  assign w_load     = ((r_state == IDLE) || (r_state == OUT)) && w_found;
  assign w_next_ptr = (w_gnt == CHW'(NCH - 1)) ? '0 : w_gnt + CHW'(1);

  assign w_diff = $signed({r_x[DW-1], r_x}) - $signed({r_yp[DW-1], r_yp});
  assign w_step = w_diff >>> r_kw;
  assign w_filt = r_yp + w_step[DW-1:0];

`ifdef LPF_PRIME_EN
  logic [NCH-1:0] r_primed;
  logic           r_pw;
  assign w_calc = r_pw ? w_filt : r_x;
`else
  assign w_calc = w_filt;
`endif

  assign ovr  = r_ovr;
  assign busy = (r_state != IDLE);

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic w_sel_load;
      logic w_sel_cfg;
      logic w_sel_out;
      assign w_sel_load = w_load && (w_gnt == CHW'(c));
      assign w_sel_cfg  = cfg_we && (cfg_ch == CHW'(c));
      assign w_sel_out  = (r_state == CALC) && (r_g == CHW'(c));

      // A strobe on the grant edge keeps the channel pending with the new value.
      always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pend[c] <= 1'b0;
          r_ovr[c]  <= 1'b0;
          r_xin[c]  <= '0;
          r_y[c]    <= '0;
          r_k[c]    <= 4'(K_RST);
        end else begin
          if (smp_stb[c]) begin
            r_xin[c]  <= vin_flat[c*DW +: DW];
            r_pend[c] <= 1'b1;
          end else if (w_sel_load) begin
            r_pend[c] <= 1'b0;
          end
          if (smp_stb[c] && r_pend[c]) begin
            r_ovr[c] <= 1'b1;
          end else if (ovr_clr) begin
            r_ovr[c] <= 1'b0;
          end
          if (w_sel_cfg) begin
            r_k[c] <= cfg_k;
          end
          if (w_sel_out) begin
            r_y[c] <= r_res;
          end
        end
      end

`ifdef LPF_PRIME_EN
      always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_primed[c] <= 1'b0;
        end else if (w_sel_cfg) begin
          r_primed[c] <= 1'b0;
        end else if (w_sel_out) begin
          r_primed[c] <= 1'b1;
        end
      end
`endif
    end
  endgenerate

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_g        <= '0;
      r_x        <= '0;
      r_yp       <= '0;
      r_kw       <= '0;
      r_res      <= '0;
      vout       <= '0;
      vout_ch    <= '0;
      vout_valid <= 1'b0;
`ifdef LPF_PRIME_EN
      r_pw       <= 1'b0;
`endif
    end else begin
      vout_valid <= 1'b0;
      case (r_state)
        IDLE, OUT: begin
          if (w_found) begin
            r_g     <= w_gnt;
            r_x     <= r_xin[w_gnt];
            r_yp    <= r_y[w_gnt];
            r_kw    <= r_k[w_gnt];
            r_ptr   <= w_next_ptr;
`ifdef LPF_PRIME_EN
            r_pw    <= r_primed[w_gnt];
`endif
            r_state <= LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD: begin
          r_res   <= w_calc;
          r_state <= CALC;
        end
        CALC: begin
          vout       <= r_res;
          vout_ch    <= r_g;
          vout_valid <= 1'b1;
          r_state    <= OUT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lpf_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lpf_channel_scheduler: directed and random stimulus against a           |
// | transaction-level reference model of the LPF channel scheduler.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_lpf_channel_scheduler;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
  localparam int DW    = 20;
  localparam int K_RST = 4;

  logic              qzt_clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    smp_stb;
  logic [DW-1:0]     vin [NCH];
  logic [NCH*DW-1:0] vin_flat;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic [3:0]        cfg_k;
  logic              ovr_clr;
  logic [DW-1:0]     vout;
  logic [CHW-1:0]    vout_ch;
  logic              vout_valid;
  logic [NCH-1:0]    ovr;
  logic              busy;

  always #5 qzt_clk = ~qzt_clk;

  always_comb begin
    vin_flat = '0;
    for (int c = 0; c < NCH; c++) vin_flat[c*DW +: DW] = vin[c];
  end

  lpf_channel_scheduler #(.NCH(NCH), .CHW(CHW), .DW(DW), .K_RST(K_RST)) dut (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .smp_stb(smp_stb), .vin_flat(vin_flat),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_k(cfg_k), .ovr_clr(ovr_clr),
    .vout(vout), .vout_ch(vout_ch), .vout_valid(vout_valid), .ovr(ovr), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: per-channel queues of one sample, filter state as integers,
  // and a three-cycle service slot per granted sample.
  int m_y[NCH], m_xin[NCH], m_k[NCH];
  bit m_pend[NCH], m_ovr[NCH];
  int m_ptr, m_slot, m_g, m_x, m_yp, m_kk, m_vout, m_ch;
  bit m_valid;

  logic [DW-1:0]  res_v[$];
  logic [CHW-1:0] res_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_y[c] = 0; m_xin[c] = 0; m_k[c] = K_RST; m_pend[c] = 0; m_ovr[c] = 0;
    end
    m_ptr = 0; m_slot = 0; m_g = 0; m_x = 0; m_yp = 0; m_kk = 0;
    m_vout = 0; m_ch = 0; m_valid = 0;
  endfunction

  function automatic void model_step();
    bit old_pend[NCH];
    for (int c = 0; c < NCH; c++) old_pend[c] = m_pend[c];
    m_valid = 0;
    if (m_slot == 1) begin
      m_slot = 2;
    end else if (m_slot == 2) begin
      m_vout = m_yp + ((m_x - m_yp) >>> m_kk);
      m_y[m_g] = m_vout;
      m_ch = m_g;
      m_valid = 1;
      m_slot = 3;
    end else begin
      m_slot = 0;
      for (int i = 0; i < NCH; i++) begin
        int g;
        g = (m_ptr + i) % NCH;
        if (old_pend[g] && m_slot == 0) begin
          m_g = g; m_x = m_xin[g]; m_yp = m_y[g]; m_kk = m_k[g];
          m_pend[g] = 0;
          m_ptr = (g + 1) % NCH;
          m_slot = 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (ovr_clr) m_ovr[c] = 0;
      if (smp_stb[c]) begin
        if (old_pend[c]) m_ovr[c] = 1;
        m_xin[c] = int'($signed(vin[c]));
        m_pend[c] = 1;
      end
    end
    if (cfg_we) m_k[cfg_ch] = int'(cfg_k);
  endfunction

  task automatic check_all();
    logic [NCH-1:0] e_ovr;
    for (int c = 0; c < NCH; c++) e_ovr[c] = m_ovr[c];
    chk("vout_valid", 32'(vout_valid), 32'(m_valid));
    chk("vout", 32'(vout), 32'(m_vout[DW-1:0]));
    chk("vout_ch", 32'(vout_ch), 32'(m_ch[CHW-1:0]));
    chk("ovr", 32'(ovr), 32'(e_ovr));
    chk("busy", 32'(busy), 32'(m_slot != 0));
    if (vout_valid) begin
      res_v.push_back(vout);
      res_c.push_back(vout_ch);
    end
  endtask

  task automatic clear_inputs();
    smp_stb = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_k = '0; ovr_clr = 1'b0;
  endtask

  // Called at a falling edge with the inputs for the next rising edge driven.
  task automatic tick();
    model_step();
    @(posedge qzt_clk);
    @(negedge qzt_clk);
    check_all();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int c, input logic [DW-1:0] v);
    smp_stb[c] = 1'b1; vin[c] = v; tick();
  endtask

  task automatic cfg(input int c, input int k);
    cfg_we = 1'b1; cfg_ch = CHW'(c); cfg_k = 4'(k); tick();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge qzt_clk);
    rst_n = 1'b1;
    res_v.delete(); res_c.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) vin[c] = '0;
    clear_inputs();
    @(negedge qzt_clk);
    do_reset();

    // Ch0 k=2, two samples of 1000.
    cfg(0, 2);
    strobe(0, 20'd1000); idle(9);
    strobe(0, 20'd1000); idle(9);
    chk("t1_n", res_v.size(), 2);
    chk("t1_r0", 32'(res_v[0]), 32'd250);
    chk("t1_r1", 32'(res_v[1]), 32'd437);
    chk("t1_ch", 32'(res_c[1]), 32'd0);

    // Ch1 negative input, then zero.
    do_reset();
    cfg(1, 2);
    strobe(1, 20'hFFC18); idle(5);
    strobe(1, 20'h00000); idle(5);
    chk("t2_r0", 32'(res_v[0]), 32'hFFF06);
    chk("t2_r1", 32'(res_v[1]), 32'hFFF44);

    // All channels at once with k=0, then the pointer wraps back to ch0.
    do_reset();
    for (int c = 0; c < NCH; c++) cfg(c, 0);
    for (int c = 0; c < NCH; c++) begin smp_stb[c] = 1'b1; vin[c] = DW'(11 * (c + 1)); end
    tick(); idle(14);
    for (int c = 0; c < NCH; c++) begin
      chk("t3_ch", 32'(res_c[c]), 32'(c));
      chk("t3_v", 32'(res_v[c]), 32'(11 * (c + 1)));
    end
    smp_stb[3] = 1'b1; smp_stb[0] = 1'b1; vin[3] = 20'd7; vin[0] = 20'd9;
    tick(); idle(8);
    chk("t3_wrap", 32'(res_c[4]), 32'd0);

    // Overrun on ch2 while ch0 is in service.
    do_reset();
    strobe(0, 20'd5);
    strobe(2, 20'd100);
    strobe(2, 20'd200);
    chk("t4_ovr", 32'(ovr[2]), 32'd1);
    idle(8);
    chk("t4_n", res_v.size(), 2);
    chk("t4_v", 32'(res_v[1]), 32'd12);
    ovr_clr = 1'b1; tick();
    chk("t4_clr", 32'(ovr[2]), 32'd0);
    strobe(0, 20'd5);
    strobe(2, 20'd100);
    smp_stb[2] = 1'b1; vin[2] = 20'd300; ovr_clr = 1'b1; tick();
    chk("t4_prio", 32'(ovr[2]), 32'd1);
    idle(8);

    // Coefficient rewrite while ch3 is mid-computation.
    do_reset();
    strobe(3, 20'd160);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_k = 4'd0; tick();
    idle(4);
    strobe(3, 20'd160); idle(4);
    chk("t5_r0", 32'(res_v[0]), 32'd10);
    chk("t5_r1", 32'(res_v[1]), 32'd160);

    // Reset during computation.
    do_reset();
    cfg(0, 1);
    strobe(0, 20'd160);
    strobe(1, 20'd50);
    do_reset();
    idle(4);
    chk("t6_none", res_v.size(), 0);
    strobe(0, 20'd160); idle(4);
    chk("t6_r", 32'(res_v[0]), 32'd10);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(7) == 0) begin
          smp_stb[c] = 1'b1;
          vin[c] = DW'($urandom);
        end
      end
      if ($urandom_range(15) == 0) begin
        cfg_we = 1'b1; cfg_ch = CHW'($urandom_range(NCH - 1)); cfg_k = 4'($urandom_range(15));
      end
      if ($urandom_range(31) == 0) ovr_clr = 1'b1;
      tick();
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lpf_channel_scheduler.md
Name: lpf_channel_scheduler

Overview:
- Time-multiplexes one single-pole low-pass filter datapath across NCH ECG acquisition channels.
- Latches per-channel sample strobes and grants channels round-robin.
- Holds per-channel filter state and shift coefficient k, and emits one filtered word per grant with its channel tag.
- Sits between the ADC/decimation front-end and downstream QRS/display logic, all on qzt_clk.

Parameters:
NCH, 4, number of channels (2..8)
CHW, 2, channel index width; must equal clog2(NCH)
DW, 20, sample/state width, two's complement
K_RST, 4, reset value of every channel's k

Ports:
qzt_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
smp_stb  input  NCH  one-cycle new-sample strobe per channel
vin_flat  input  NCH*DW  channel c sample at bits [c*DW +: DW]
cfg_we  input  1  write cfg_k into channel cfg_ch
cfg_ch  input  CHW  config target channel
cfg_k  input  4  shift coefficient, 0..15
ovr_clr  input  1  clears all ovr bits
vout  output  DW  filtered result
vout_ch  output  CHW  channel of vout
vout_valid  output  1  one-cycle result strobe
ovr  output  NCH  sticky overrun flag per channel
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, rst_n low): vout=0, vout_ch=0, vout_valid=0, ovr=0, busy=0; all pending flags, input latches and states y[c] =0; k[c]=K_RST; RR pointer=0; FSM=IDLE.
- Capture: when smp_stb[c]=1 at an edge, xin[c] <= vin_flat slice and pend[c] <= 1.
- Overrun: a strobe while pend[c] is already 1 overwrites xin[c] and sets ovr[c].
- ovr_clr: clears ovr. A same-edge set takes priority over the clear.
- FSM states: IDLE, LOAD, CALC, OUT.
- IDLE: if any pend is set, go to LOAD. Otherwise stay.
- LOAD (entered at edge E1):
  - g = first pending channel at or after the RR pointer, wrapping modulo NCH.
  - Copy xin[g], y[g] and k[g] into working registers; clear pend[g]; pointer <= g+1 mod NCH.
  - If smp_stb[g] occurs at E1, the strobe wins: pend[g] stays 1, xin[g] takes the new value, and the old value is processed.
- CALC (E2):
  - diff = sext(DW+1, x) - sext(DW+1, yp).
  - step = diff >>> k (arithmetic).
  - r = yp + step, taken as DW bits.
  - The result always lies between yp and x, so no saturation exists.
- OUT (E3):
  - y[g] <= r; vout <= r; vout_ch <= g; vout_valid = 1 for exactly the cycle after E3.
  - Next state is LOAD if any pend is set, else IDLE.
- Latency: strobe at E0 gives vout_valid high after E3 (3 edges after the strobe edge).
- Throughput: one result every 3 cycles when continuously pending.
- Config writes: k[cfg_ch] updates at the edge; the write always succeeds.
  - k is sampled at LOAD, so a write during an in-flight computation affects only the next sample of that channel.
- busy = (state != IDLE).
- Reset mid-operation aborts the computation. No vout_valid is produced and the state write is lost.
- k=0 gives r = x. k=15 gives minimal movement; step may be -1 for small negative diff due to floor shift.

Optional Feature:
Macro LPF_PRIME_EN.
- Defined:
  - Per-channel primed bit, cleared on reset and on any cfg_we to that channel.
  - While the bit is 0, CALC forces r = x (filter seeded with the first sample), and OUT sets the bit.
  - This removes the startup transient.
- Undefined: no primed bits. State starts at 0 and the filter always applies.

Test Plan:
- Ch0 k=2, strobe vin=1000 twice, spaced 10 cycles -> vout 250 then 437, vout_ch=0; each vout_valid 3 edges after its strobe (without LPF_PRIME_EN; with it -> 1000, 1000).
- Ch1 k=2, vin=-1000 (0xFFC18) from reset -> vout=-250 (0xFFF06). Then vin=0 -> -188 (0xFFF44).
- All four strobed same cycle, distinct values, k=0 -> outputs in order ch0,1,2,3, each vout = its input, valids 3 cycles apart, pointer resumes at 0.
- Ch2 strobed twice within 2 cycles before grant -> single result from the second value; ovr[2]=1 until ovr_clr. A simultaneous strobe+ovr_clr leaves ovr set.
- cfg_we ch3 k=0 during CALC of ch3 (k was 4, y=0, x=160) -> current result 10; next x=160 -> 160.
- Assert rst_n low during CALC -> vout_valid never asserts, ovr/pend/y cleared. Re-strobe after release -> result computed from y=0 and k=K_RST.
